// File: rtl/video_arbiter.sv
// Video/CPU arbiter for the shared DRAM port.
// Grants DRAM cycles to the video fetcher at the requested bandwidth (1/8, 1/4, 1/2 or all
// cycles) and gives every remaining cycle to the CPU. A grant decision is taken on each cend
// clk and frames the following DRAM cycle.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cbeg, pre_cend, cend           DRAM cycle framing strobes
//   video_go/bw/addr               video request, bandwidth select, fetch address
//   video_next/strobe/data         video address-consumed pulse, data-valid pulse, read data
//   cpu_req/rnw/addr/wrdata        CPU request, direction, address, write data
//   cpu_next/strobe/rddata         CPU accept pulse, done pulse, read data
//   dram_req/rnw/addr/wrdata       cycle request towards the DRAM controller
//   dram_rddata                    read data from the controller, valid on pre_cend
module video_arbiter #(
    parameter int unsigned AW = 21,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cbeg,
    input  logic          pre_cend,
    input  logic          cend,
    input  logic          video_go,
    input  logic [1:0]    video_bw,
    input  logic [AW-1:0] video_addr,
    output logic          video_next,
    output logic          video_strobe,
    output logic [DW-1:0] video_data,
    input  logic          cpu_req,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wrdata,
    output logic          cpu_next,
    output logic          cpu_strobe,
    output logic [DW-1:0] cpu_rddata,
    output logic          dram_req,
    output logic          dram_rnw,
    output logic [AW-1:0] dram_addr,
    output logic [DW-1:0] dram_wrdata,
    input  logic [DW-1:0] dram_rddata
);

    localparam logic [1:0] TypeIdle  = 2'd0;
    localparam logic [1:0] TypeVideo = 2'd1;
    localparam logic [1:0] TypeCpu   = 2'd2;

    logic [2:0]    slot_q, slot_d;
    logic [1:0]    type_q, type_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rnw_q, rnw_d;
    logic [DW-1:0] wrdata_q, wrdata_d;
    logic [DW-1:0] vdata_q, vdata_d;
    logic [DW-1:0] cdata_q, cdata_d;
    logic          video_slot;

    // Low slot bits that must be zero for a video slot shrink as bandwidth grows.
    always_comb begin
        video_slot = 1'b0;
        unique case (video_bw)
            2'b00:   video_slot = (slot_q == 3'd0);
            2'b01:   video_slot = (slot_q[1:0] == 2'd0);
            2'b10:   video_slot = ~slot_q[0];
            2'b11:   video_slot = 1'b1;
            default: video_slot = 1'b0;
        endcase
    end

    always_comb begin
        slot_d   = slot_q;
        type_d   = type_q;
        addr_d   = addr_q;
        rnw_d    = rnw_q;
        wrdata_d = wrdata_q;
        vdata_d  = vdata_q;
        cdata_d  = cdata_q;

        if (pre_cend) begin
            if (type_q == TypeVideo) begin
                vdata_d = dram_rddata;
            end else if (type_q == TypeCpu && rnw_q) begin
                cdata_d = dram_rddata;
            end
        end

        // The cend that closes one cycle also picks the owner of the next one.
        if (cend) begin
            slot_d = slot_q + 3'd1;
            if (video_slot && video_go) begin
                type_d = TypeVideo;
                addr_d = video_addr;
                rnw_d  = 1'b1;
            end else if (cpu_req) begin
                type_d   = TypeCpu;
                addr_d   = cpu_addr;
                rnw_d    = cpu_rnw;
                wrdata_d = cpu_wrdata;
            end else begin
                // Idle keeps the last address/data on the bus; only dram_req drops.
                type_d = TypeIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            type_q   <= TypeIdle;
            addr_q   <= '0;
            rnw_q    <= 1'b0;
            wrdata_q <= '0;
            vdata_q  <= '0;
            cdata_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            rnw_q    <= rnw_d;
            wrdata_q <= wrdata_d;
            vdata_q  <= vdata_d;
            cdata_q  <= cdata_d;
        end
    end

    // Pulses are gated by the registered grant, so a reset mid-cycle kills them at once.
    assign video_next   = cbeg && (type_q == TypeVideo);
    assign cpu_next     = cbeg && (type_q == TypeCpu);
    assign video_strobe = cend && (type_q == TypeVideo);
    assign cpu_strobe   = cend && (type_q == TypeCpu);

    assign video_data  = vdata_q;
    assign cpu_rddata  = cdata_q;
    assign dram_req    = (type_q != TypeIdle);
    assign dram_rnw    = rnw_q;
    assign dram_addr   = addr_q;
    assign dram_wrdata = wrdata_q;

endmodule

// File: tb/tb_video_arbiter.sv
// Bench for video_arbiter: directed scenarios followed by randomized traffic, all checked
// against a cycle-level reference model of the grant rules.
module tb_video_arbiter;

    localparam int AW = 21;
    localparam int DW = 16;
    localparam int MI = 0;
    localparam int MV = 1;
    localparam int MC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cbeg = 1'b0, pre_cend = 1'b0, cend = 1'b0;
    logic          video_go = 1'b0;
    logic [1:0]    video_bw = 2'b00;
    logic [AW-1:0] video_addr = '0;
    logic          video_next, video_strobe;
    logic [DW-1:0] video_data;
    logic          cpu_req = 1'b0, cpu_rnw = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wrdata = '0;
    logic          cpu_next, cpu_strobe;
    logic [DW-1:0] cpu_rddata;
    logic          dram_req, dram_rnw;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wrdata;
    logic [DW-1:0] dram_rddata = '0;

    video_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cbeg         (cbeg),
        .pre_cend     (pre_cend),
        .cend         (cend),
        .video_go     (video_go),
        .video_bw     (video_bw),
        .video_addr   (video_addr),
        .video_next   (video_next),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .cpu_req      (cpu_req),
        .cpu_rnw      (cpu_rnw),
        .cpu_addr     (cpu_addr),
        .cpu_wrdata   (cpu_wrdata),
        .cpu_next     (cpu_next),
        .cpu_strobe   (cpu_strobe),
        .cpu_rddata   (cpu_rddata),
        .dram_req     (dram_req),
        .dram_rnw     (dram_rnw),
        .dram_addr    (dram_addr),
        .dram_wrdata  (dram_wrdata),
        .dram_rddata  (dram_rddata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit rnd_mode = 1'b0;
    int vnext_cnt, vstb_cnt, cnext_cnt, cstb_cnt;

    // Reference model: owner of the cycle in progress, cycle counter modulo 8, bus contents.
    int            m_type;
    int            m_slot;
    logic [AW-1:0] m_addr;
    logic          m_rnw;
    logic [DW-1:0] m_wr, m_vdata, m_cdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_type = MI; m_slot = 0; m_addr = '0; m_rnw = 1'b0;
        m_wr = '0; m_vdata = '0; m_cdata = '0;
    endtask

    task automatic clear_counts();
        vnext_cnt = 0; vstb_cnt = 0; cnext_cnt = 0; cstb_cnt = 0;
    endtask

    task automatic rand_inputs();
        video_go    = 1'($urandom_range(0, 1));
        video_bw    = 2'($urandom_range(0, 3));
        video_addr  = AW'($urandom);
        cpu_req     = 1'($urandom_range(0, 1));
        cpu_rnw     = 1'($urandom_range(0, 1));
        cpu_addr    = AW'($urandom);
        cpu_wrdata  = DW'($urandom);
        dram_rddata = DW'($urandom);
    endtask

    task automatic check_outputs(input bit cb, input bit ce);
        check("video_next",   video_next,   cb && m_type == MV);
        check("cpu_next",     cpu_next,     cb && m_type == MC);
        check("video_strobe", video_strobe, ce && m_type == MV);
        check("cpu_strobe",   cpu_strobe,   ce && m_type == MC);
        check("dram_req",     dram_req,     m_type != MI);
        check("dram_addr",    dram_addr,    m_addr);
        check("dram_rnw",     dram_rnw,     m_rnw);
        check("dram_wrdata",  dram_wrdata,  m_wr);
        check("video_data",   video_data,   m_vdata);
        check("cpu_rddata",   cpu_rddata,   m_cdata);
    endtask

    task automatic model_update(input bit pc, input bit ce);
        int period;
        if (pc) begin
            if (m_type == MV) m_vdata = dram_rddata;
            else if (m_type == MC && m_rnw) m_cdata = dram_rddata;
        end
        if (ce) begin
            // Video owns one cycle in every 8, 4, 2 or 1, counted from cycle 0 after reset.
            period = 8 >> video_bw;
            if (video_go && (m_slot % period) == 0) begin
                m_type = MV; m_addr = video_addr; m_rnw = 1'b1;
            end else if (cpu_req) begin
                m_type = MC; m_addr = cpu_addr; m_rnw = cpu_rnw; m_wr = cpu_wrdata;
            end else begin
                m_type = MI;
            end
            m_slot = (m_slot + 1) % 8;
        end
    endtask

    // One clk: drive strobes after the edge, check at the falling edge, advance the model.
    task automatic clk_step(input bit cb, input bit pc, input bit ce);
        if (rnd_mode) rand_inputs();
        cbeg = cb; pre_cend = pc; cend = ce;
        @(negedge clk);
        check_outputs(cb, ce);
        if (video_next) vnext_cnt++;
        if (video_strobe) vstb_cnt++;
        if (cpu_next) cnext_cnt++;
        if (cpu_strobe) cstb_cnt++;
        @(posedge clk);
        #1;
        if (rst_n) model_update(pc, ce);
        cbeg = 1'b0; pre_cend = 1'b0; cend = 1'b0;
    endtask

    task automatic dram_cycle(input int gap_mid, input int gap_after);
        clk_step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < gap_mid; i++) clk_step(1'b0, 1'b0, 1'b0);
        clk_step(1'b0, 1'b1, 1'b0);
        clk_step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < gap_after; i++) clk_step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_model();
        clear_counts();

        // Reset state.
        clk_step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Lowest bandwidth, no CPU: two video cycles in sixteen.
        video_bw = 2'b00; video_go = 1'b1; video_addr = 21'h0_1000; cpu_req = 1'b0;
        clear_counts();
        for (int i = 0; i < 16; i++) dram_cycle(1, 0);
        check("bw00_vnext_cnt", vnext_cnt, 2);
        check("bw00_vstb_cnt", vstb_cnt, 2);

        // Quarter bandwidth with CPU always requesting: V,C,C,C,V,C,C,C.
        video_bw = 2'b01; cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h0_0777;
        clear_counts();
        for (int i = 0; i < 9; i++) dram_cycle(0, 1);
        check("bw01_cnext_cnt", cnext_cnt, 6);
        check("bw01_vnext_cnt", vnext_cnt, 2);

        // Full bandwidth locks the CPU out until video_go drops.
        video_bw = 2'b11;
        dram_cycle(1, 0);
        clear_counts();
        for (int i = 0; i < 8; i++) dram_cycle(1, 0);
        check("bw11_cnext_cnt", cnext_cnt, 0);
        check("bw11_vnext_cnt", vnext_cnt, 8);
        video_go = 1'b0;
        clear_counts();
        dram_cycle(1, 0);
        dram_cycle(1, 0);
        check("go_off_vnext_cnt", vnext_cnt, 1);
        check("go_off_cnext_cnt", cnext_cnt, 1);

        // CPU read then CPU write.
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h1_2345;
        dram_cycle(1, 0);
        check("rd_dram_addr", dram_addr, 21'h1_2345);
        check("rd_dram_rnw", dram_rnw, 1'b1);
        cpu_rnw = 1'b0; cpu_addr = 21'h0_0F0F; cpu_wrdata = 16'h5A5A; dram_rddata = 16'hBEEF;
        dram_cycle(1, 0);
        check("rd_cpu_rddata", cpu_rddata, 16'hBEEF);
        check("wr_dram_rnw", dram_rnw, 1'b0);
        check("wr_dram_wrdata", dram_wrdata, 16'h5A5A);
        cpu_req = 1'b0; dram_rddata = 16'h1234;
        clear_counts();
        dram_cycle(1, 0);
        check("wr_cpu_rddata_hold", cpu_rddata, 16'hBEEF);
        check("wr_cstb_cnt", cstb_cnt, 1);
        check("idle_dram_req", dram_req, 1'b0);

        // video_go dropped on cbeg of a granted video cycle.
        video_go = 1'b1; video_addr = 21'h0_0ABC;
        dram_cycle(1, 0);
        clear_counts();
        video_go = 1'b0;
        clk_step(1'b1, 1'b0, 1'b0);
        dram_rddata = 16'hC0DE;
        clk_step(1'b0, 1'b1, 1'b0);
        clk_step(1'b0, 1'b0, 1'b1);
        check("drop_vstb_cnt", vstb_cnt, 1);
        check("drop_video_data", video_data, 16'hC0DE);
        check("drop_next_not_video", dram_req, 1'b0);

        // Reset between cbeg and pre_cend of a video cycle.
        video_go = 1'b1;
        dram_cycle(1, 0);
        clk_step(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        reset_model();
        #1;
        check("rst_dram_req", dram_req, 1'b0);
        check("rst_video_strobe", video_strobe, 1'b0);
        check("rst_dram_addr", dram_addr, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        video_bw = 2'b00;
        clear_counts();
        clk_step(1'b0, 1'b1, 1'b0);
        clk_step(1'b0, 1'b0, 1'b1);
        check("rst_no_vstb", vstb_cnt, 0);
        check("rst_slot0_grant", dram_req, 1'b1);
        dram_cycle(0, 0);
        check("rst_slot1_idle", dram_req, 1'b0);

        // Randomized traffic with irregular cycle lengths and gaps without cend.
        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            dram_cycle($urandom_range(0, 2), $urandom_range(0, 2));
        end
        rnd_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_arbiter.md
Name: video_arbiter

Overview:
- Responder side of the video memory port. Grants DRAM cycles to the video fetcher according to the requested bandwidth, and gives all remaining cycles to the CPU.
- Sits between the video subsystem (video_go/video_bw/video_addr in, video_next/video_strobe/video_data out) and the DRAM controller.
- Time base is the shared 28 MHz clk. Each DRAM cycle is framed by the cbeg/pre_cend/cend strobes.

Parameters:
- AW, 21, DRAM word address width.
- DW, 16, DRAM data width.

Ports:
- clk  in  1  28 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- cbeg  in  1  first clk of a DRAM cycle (1-clk pulse)
- pre_cend  in  1  clk before cend; dram_rddata valid on this clk
- cend  in  1  last clk of a DRAM cycle (1-clk pulse)
- video_go  in  1  video fetcher requests cycles
- video_bw  in  2  bandwidth: 00=1/8, 01=1/4, 10=1/2, 11=full
- video_addr  in  AW  word address of next video fetch
- video_next  out  1  1-clk pulse: video_addr consumed, fetcher advances
- video_strobe  out  1  1-clk pulse: video_data valid
- video_data  out  DW  registered video read data
- cpu_req  in  1  CPU requests a cycle
- cpu_rnw  in  1  1=read, 0=write
- cpu_addr  in  AW  CPU word address
- cpu_wrdata  in  DW  CPU write data
- cpu_next  out  1  1-clk pulse: CPU request accepted
- cpu_strobe  out  1  1-clk pulse: CPU cycle done, cpu_rddata valid on reads
- cpu_rddata  out  DW  registered CPU read data
- dram_req  out  1  DRAM cycle active, held for the whole cycle
- dram_rnw  out  1  cycle direction
- dram_addr  out  AW  cycle address
- dram_wrdata  out  DW  write data
- dram_rddata  in  DW  read data from controller

Behaviour:
Reset (rst_n=0, asynchronous):
- All outputs 0. slot counter 0. cycle type IDLE.
- The next cend after release is the first decision point.

Slot counter:
- 3-bit counter, increments on every cend clk, wraps 7->0.
- A slot is "video slot" when:
  - bw=00: slot==0
  - bw=01: slot[1:0]==0
  - bw=10: slot[0]==0
  - bw=11: always
- The decision on a cend clk uses the slot value before that increment.

Decision, made on each cend clk; it registers the type of the following cycle:
- VIDEO if video slot and video_go=1.
- Else CPU if cpu_req=1. This includes unused video slots.
- Else IDLE.
- Video has strict priority within its slots. The CPU is never starved when bw<11.

Registered on the decision clk:
- dram_req = (type != IDLE).
- dram_addr/dram_rnw/dram_wrdata:
  - VIDEO: video_addr, rnw=1, wrdata unchanged.
  - CPU: cpu_addr/cpu_rnw/cpu_wrdata.
- These values hold until the next cend.
- IDLE clears dram_req only; address and data hold.

Handshakes within a granted cycle:
- video_next / cpu_next pulse on the cbeg clk of the granted cycle, i.e. the clk after the decision.
- On the pre_cend clk: video_data / cpu_rddata (reads only) latch dram_rddata.
- On the cend clk ending the cycle: video_strobe / cpu_strobe pulse. This is the same clk as the next decision.
- CPU writes: cpu_strobe pulses, cpu_rddata unchanged.
- Latency: decision -> next = 1 clk; decision -> strobe = one full DRAM cycle.

Boundary conditions:
- video_go falling mid-cycle: the current cycle completes and its strobe is still issued.
- video_bw change: takes effect at the next decision. The slot counter is not reset.
- cpu_req dropped after a grant: the cycle completes (the grant is committed).
- cend absent: nothing advances and all outputs hold.
- rst_n asserted mid-cycle: outputs drop immediately. No strobe is issued for the aborted cycle.
- cbeg/pre_cend/cend outside a granted cycle (IDLE): no pulses, no data latch.

Test Plan:
- Reset, then bw=00, video_go=1, cpu_req=0, 16 DRAM cycles -> exactly 2 VIDEO cycles (slots 0 of each wrap); 2 video_next and 2 video_strobe pulses; all other cycles IDLE (dram_req=0).
- bw=01, video_go=1, cpu_req=1 held, 8 cycles -> cycle sequence V,C,C,C,V,C,C,C; cpu_next count=6.
- bw=11, video_go=1, cpu_req=1 -> all cycles VIDEO, zero cpu_next. Then video_go=0 -> the next decision grants CPU.
- CPU read at cpu_addr=21'h1_2345, controller returns 16'hBEEF at pre_cend -> dram_addr=21'h1_2345, dram_rnw=1; cpu_strobe pulses on cend with cpu_rddata=16'hBEEF. CPU write -> dram_rnw=0, dram_wrdata=cpu_wrdata, cpu_rddata unchanged.
- video_go dropped on the cbeg clk of a VIDEO cycle -> video_strobe still pulses at that cycle's cend with video_data=dram_rddata; the next decision is not VIDEO.
- rst_n pulsed low between cbeg and pre_cend of a VIDEO cycle -> dram_req/video_strobe go 0 asynchronously; no strobe for that cycle; slot counter restarts at 0.
